// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One outstanding request; the response is a single-cycle strobe.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time, feeds IF/ID
// through a 1-entry skid buffer and squashes in-flight fetches made stale by a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               ifid_flush,
    input  logic               stall_if,
    if_fetch_unit_if.master    imem,
    output logic               if_id_valid,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic [31:0]        pc_if
);

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_plus4;
    logic        skid_valid, skid_valid_n;
    logic [31:0] skid_data, skid_data_n;
    logic [31:0] skid_pc4, skid_pc4_n;
    logic        ifid_valid_n;
    logic [31:0] ifid_instr_n;
    logic [31:0] ifid_pc4_n;
    logic        req_fire;
    logic        resp_take;

    assign pc_plus4            = pc + 32'd4;
    assign imem.imem_req_valid = (state == ST_REQ) && !skid_valid && !redirect_valid;
    assign imem.imem_req_addr  = pc;
    assign pc_if               = pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    // Only an unsquashed response in WAIT, with no redirect or flush, reaches IF/ID.
    assign resp_take           = (state == ST_WAIT) && imem.imem_resp_valid
                                 && !redirect_valid && !ifid_flush;

    // Next-state, PC, skid and IF/ID update.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_pc4_n   = skid_pc4;
        ifid_valid_n = if_id_valid;
        ifid_instr_n = if_id_instr;
        ifid_pc4_n   = if_id_pc4;

        case (state)
            ST_REQ: begin
                if (req_fire) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem.imem_resp_valid)  state_n = ST_REQ;
                else if (redirect_valid)   state_n = ST_SQUASH;
            end
            ST_SQUASH: begin
                // The stale response is swallowed here, even if another redirect lands with it.
                if (imem.imem_resp_valid) state_n = ST_REQ;
            end
            default: state_n = ST_REQ;
        endcase

        if (redirect_valid) begin
            pc_n         = redirect_pc;
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_INSTR;
            skid_valid_n = 1'b0;
        end else if (ifid_flush) begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_INSTR;
            skid_valid_n = 1'b0;
        end else begin
            if (resp_take) pc_n = pc_plus4;

            if (stall_if) begin
                if (resp_take) begin
                    skid_valid_n = 1'b1;
                    skid_data_n  = imem.imem_resp_data;
                    skid_pc4_n   = pc_plus4;
                end
            end else if (skid_valid) begin
                ifid_valid_n = 1'b1;
                ifid_instr_n = skid_data;
                ifid_pc4_n   = skid_pc4;
                skid_valid_n = 1'b0;
            end else if (resp_take) begin
                ifid_valid_n = 1'b1;
                ifid_instr_n = imem.imem_resp_data;
                ifid_pc4_n   = pc_plus4;
            end else begin
                ifid_valid_n = 1'b0;
                ifid_instr_n = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            skid_valid  <= 1'b0;
            skid_data   <= 32'h0;
            skid_pc4    <= 32'h0;
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            skid_valid  <= skid_valid_n;
            skid_data   <= skid_data_n;
            skid_pc4    <= skid_pc4_n;
            if_id_valid <= ifid_valid_n;
            if_id_instr <= ifid_instr_n;
            if_id_pc4   <= ifid_pc4_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural imem, directed stimulus, and an IF/ID scoreboard
// that pops one expected {instr, pc4} each time decode consumes a valid slot.
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_flush;
    logic        stall_if;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [31:0] pc_if;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_flush     (ifid_flush),
        .stall_if       (stall_if),
        .imem           (bus),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .pc_if          (pc_if)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    int          lat = 1;
    int          cnt = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        fire_q = 1'b0;
    logic [31:0] fire_addr = 32'h0;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_data = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h8C01_0000;
            32'h0000_0004: mem_word = 32'h8C02_0004;
            32'h0000_0008: mem_word = 32'h0022_1820;
            32'h0000_0010: mem_word = 32'hDEAD_BEEF;
            32'h0000_0100: mem_word = 32'h1234_5678;
            32'h0000_003C: mem_word = 32'hAC03_003C;
            32'h0000_0040: mem_word = 32'h2002_0005;
            32'h0000_0044: mem_word = 32'h3C01_1234;
            32'hFFFF_FFFC: mem_word = 32'h0800_0000;
            default:       mem_word = 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
        sb.delete();
    endtask

    // Handshake is sampled mid-cycle, so it reflects the values seen at the next rising edge.
    always @(negedge clk) begin
        fire_q    = !rst && bus.imem_req_valid && bus.imem_req_ready;
        fire_addr = bus.imem_req_addr;
    end

    // imem model: response strobe 'lat' cycles after the accepting edge; reset abandons it.
    always @(posedge clk) begin
        #1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (fire_q) begin
                cnt       = lat;
                pend_addr = fire_addr;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_resp_valid = 1'b1;
                    bus.imem_resp_data  = mem_word(pend_addr);
                end
            end
            if (inj_valid) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = inj_data;
                inj_valid           = 1'b0;
            end
        end
    end

    // Scoreboard monitor and skid/WAIT invariant.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (dut.skid_valid && (dut.state == 2'd1)) begin
                errors++;
                $display("FAIL invariant skid_valid=1 with state=WAIT expected not both");
            end
            if (if_id_valid && !stall_if) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ifid instr=%h pc4=%h expected=none", if_id_instr, if_id_pc4);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_instr", if_id_instr, e.instr);
                    chk("sb_pc4", if_id_pc4, e.pc4);
                end
            end
        end
    end

    initial begin
        rst                = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        ifid_flush         = 1'b0;
        stall_if           = 1'b0;
        bus.imem_req_ready = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_pc_if", pc_if, 32'h0);
        chk("rst_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("rst_if_id_instr", if_id_instr, 32'h0);
        chk("rst_if_id_pc4", if_id_pc4, 32'h0);
        tick();
        tick();
        bus.imem_req_ready = 1'b1;
        #1 rst = 1'b0;

        // Straight-line fetch, 1-cycle memory
        sb.push_back('{instr: 32'h8C01_0000, pc4: 32'h0000_0004});
        sb.push_back('{instr: 32'h8C02_0004, pc4: 32'h0000_0008});
        sb.push_back('{instr: 32'h0022_1820, pc4: 32'h0000_000C});
        @(negedge clk);
        chk("req_valid_after_rst", 32'(bus.imem_req_valid), 32'h1);
        chk("req_addr_after_rst", bus.imem_req_addr, 32'h0);
        repeat (5) tick();
        bus.imem_req_ready = 1'b0;
        drain();
        chk("pc_after_line", pc_if, 32'h0000_000C);

        // Redirect while a fetch to 0x10 is outstanding
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        @(negedge clk);
        chk("no_req_in_redirect_cycle", 32'(bus.imem_req_valid), 32'h0);
        tick();
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b1;
        lat                = 2;
        tick();
        redirect_valid     = 1'b1;
        redirect_pc        = 32'h0000_0100;
        bus.imem_req_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("squash_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("squash_pc_if", pc_if, 32'h0000_0100);
        tick();
        @(negedge clk);
        chk("after_squash_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("after_squash_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("after_squash_req_addr", bus.imem_req_addr, 32'h0000_0100);

        // Redirect coincident with the response
        tick();
        bus.imem_req_ready = 1'b1;
        lat                = 1;
        tick();
        redirect_valid     = 1'b1;
        redirect_pc        = 32'h0000_0200;
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("coinc_no_req", 32'(bus.imem_req_valid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("coinc_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("coinc_req_addr", bus.imem_req_addr, 32'h0000_0200);

        // Decode stall: 0x3C held in IF/ID, 0x40 lands in the skid
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_003C;
        tick();
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b1;
        sb.push_back('{instr: 32'hAC03_003C, pc4: 32'h0000_0040});
        sb.push_back('{instr: 32'h2002_0005, pc4: 32'h0000_0044});
        tick();
        tick();
        stall_if = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        tick();
        @(negedge clk);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("stall_if_id_valid", 32'(if_id_valid), 32'h1);
        chk("stall_if_id_instr", if_id_instr, 32'hAC03_003C);
        chk("stall_if_id_pc4", if_id_pc4, 32'h0000_0040);
        chk("stall_pc_if", pc_if, 32'h0000_0044);
        tick();
        @(negedge clk);
        chk("stall_hold_instr", if_id_instr, 32'hAC03_003C);
        tick();
        stall_if = 1'b0;
        @(negedge clk);
        chk("skid_blocks_req", 32'(bus.imem_req_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("after_skid_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("after_skid_req_addr", bus.imem_req_addr, 32'h0000_0044);
        drain();

        // Flush with a coincident response: dropped, same pc re-fetched
        tick();
        bus.imem_req_ready = 1'b1;
        sb.push_back('{instr: 32'h3C01_1234, pc4: 32'h0000_0048});
        tick();
        ifid_flush = 1'b1;
        tick();
        ifid_flush = 1'b0;
        @(negedge clk);
        chk("flush_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("flush_pc_if", pc_if, 32'h0000_0044);
        chk("flush_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("flush_req_addr", bus.imem_req_addr, 32'h0000_0044);
        tick();
        bus.imem_req_ready = 1'b0;
        drain();

        // PC wrap at the top of the address space
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b1;
        sb.push_back('{instr: 32'h0800_0000, pc4: 32'h0000_0000});
        tick();
        bus.imem_req_ready = 1'b0;
        drain();
        chk("wrap_pc_if", pc_if, 32'h0000_0000);

        // Async reset with IF/ID valid and a fetch outstanding
        tick();
        bus.imem_req_ready = 1'b1;
        tick();
        lat = 2;
        tick();
        stall_if = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_if_id_valid", 32'(if_id_valid), 32'h1);
        chk("pre_rst_if_id_instr", if_id_instr, 32'h8C01_0000);
        chk("pre_rst_pc_if", pc_if, 32'h0000_0004);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("mid_rst_if_id_instr", if_id_instr, 32'h0);
        chk("mid_rst_if_id_pc4", if_id_pc4, 32'h0);
        chk("mid_rst_pc_if", pc_if, 32'h0);
        tick();
        #1;
        rst      = 1'b0;
        stall_if = 1'b0;
        lat      = 1;
        @(negedge clk);
        inj_valid = 1'b1;
        inj_data  = 32'hBAD0_0001;
        tick();
        tick();
        @(negedge clk);
        chk("late_resp_if_id_valid", 32'(if_id_valid), 32'h0);
        chk("late_resp_if_id_instr", if_id_instr, 32'h0);
        chk("late_resp_pc_if", pc_if, 32'h0);
        chk("late_resp_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("late_resp_req_addr", bus.imem_req_addr, 32'h0);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
